stopwatch_bcd_counter: RTL
==========================

// Module: stopwatch_bcd_counter
// PURPOSE
//  Stopwatch timebase and 8-digit BCD time counter, HH:MM:SS.cc (00:00:00.00 .. 99:59:59.99).
//  Sits directly upstream of the 8-digit display multiplexer and drives its bit0..bit7 digit inputs.
//  Control comes from single-cycle pulses (start_stop, clear, lap) issued by the debounced button front end.
// PARAMETERS
//  CLK_HZ   100_000_000  input clock frequency, Hz
//  TICK_HZ  100          count rate, Hz (1 tick = 1 centisecond)
//  DIV = CLK_HZ/TICK_HZ (derived localparam, >=2); prescaler width = $clog2(DIV)
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  reset       in   1  synchronous, active-high reset
//  start_stop  in   1  1-cycle pulse: start/resume or pause
//  clear       in   1  1-cycle pulse: zero the count, return to IDLE
//  lap         in   1  1-cycle pulse: toggle lap hold (LAP_HOLD_EN only)
//  bit0..bit7  out  4  displayed BCD digits: bit0=cs units, bit1=cs tens, bit2=s units, bit3=s tens(0-5),
//                      bit4=min units, bit5=min tens(0-5), bit6=hr units, bit7=hr tens
//  running     out  1  1 while in RUNNING
//  ovf         out  1  sticky: count wrapped past 99:59:59.99
//  lap_active  out  1  1 while displayed digits are frozen (lap hold)
// BEHAVIOUR
//  Reset (sync, highest priority): state=IDLE, prescaler=0, all digits=0, running=0, ovf=0, lap_active=0.
//  FSM: IDLE -start_stop-> RUNNING; RUNNING -start_stop-> PAUSED; PAUSED -start_stop-> RUNNING;
//       any state -clear-> IDLE (digits=0, prescaler=0, ovf=0, lap_active=0).
//  Priority in one cycle: reset > clear > start_stop > lap. clear+start_stop together -> IDLE, not running.
//  Prescaler: counts 0..DIV-1 only in RUNNING; tick asserted internally when prescaler==DIV-1 in RUNNING,
//   prescaler then returns to 0. Prescaler holds its value in PAUSED (no lost fraction on resume).
//  First tick after start occurs DIV cycles after the start_stop pulse cycle; digits update on the clock
//   edge that consumes the tick (registered outputs, no combinational path from inputs to bit0..bit7).
//  A start_stop pulse arriving in the same cycle as a tick: the tick is applied, then state -> PAUSED.
//  Increment: ripple carry, each digit wraps at its limit (9, or 5 for bit3/bit5) and carries up;
//   hours run 00..99 (no 24 h wrap). From 99:59:59.99 the next tick yields all zeros and sets ovf=1;
//   counting continues; ovf stays set until clear or reset.
//  Digits never hold non-BCD values; tens-of-seconds/minutes never exceed 5.
//  running is a registered decode of state (1 exactly in RUNNING).
// CONFIGURATION
//  Macro LAP_HOLD_EN defined: separate live and displayed digit registers. lap in RUNNING with
//   lap_active=0 -> copy live count to display, lap_active=1, display frozen while live count continues.
//   lap with lap_active=1 (RUNNING or PAUSED) -> lap_active=0, display tracks live again next cycle.
//   lap in IDLE, or in PAUSED with lap_active=0, is ignored. clear drops lap_active.
//  Macro undefined: lap input ignored, lap_active tied 0, bit0..bit7 are the live count registers.
// TESTING  (bench uses CLK_HZ=10, TICK_HZ=1 -> DIV=10)
//  Reset held 2 cycles -> all digits 0, running=0, ovf=0, lap_active=0.
//  start_stop pulse, run 250 cycles -> 25 ticks: bit1=2, bit0=5, others 0, running=1.
//  start_stop after 43 cycles, wait 100, start_stop, run 7 more -> count 00:00:00.05 (prescaler kept).
//  Force count 00:00:59.99 (run 5999 ticks), one more tick -> bit4=1, bits3..0=0 (seconds/cs carry).
//  Reach 99:59:59.99, one tick -> all digits 0, ovf=1; clear -> IDLE, ovf=0; clear+start_stop same cycle -> running=0.
//  LAP_HOLD_EN: lap at 12 ticks, run 30 ticks -> display 00:00:00.12; lap again -> display 00:00:00.42.

Source files
------------

// File: rtl/stopwatch_bcd_counter_if.sv
// Control pulses from the button front end and the BCD digit/status bundle
// going to the display multiplexer.
interface stopwatch_bcd_counter_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] bit0, bit1, bit2, bit3, bit4, bit5, bit6, bit7;
  logic       running;
  logic       ovf;
  logic       lap_active;

  modport master (
    output start_stop, clear, lap,
    input  bit0, bit1, bit2, bit3, bit4, bit5, bit6, bit7, running, ovf, lap_active
  );

  modport slave (
    input  start_stop, clear, lap,
    output bit0, bit1, bit2, bit3, bit4, bit5, bit6, bit7, running, ovf, lap_active
  );
endinterface

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch timebase + 8-digit BCD HH:MM:SS.cc counter with sticky overflow.
// Optional lap hold (frozen display while counting continues) under macro LAP_HOLD_EN.
module stopwatch_bcd_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  stopwatch_bcd_counter_if.slave  sw
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  // Digits 3 and 5 (tens of seconds/minutes) wrap at 5, all others at 9.
  localparam logic [7:0] SIX_MASK = 8'b0010_1000;

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [7:0][3:0]      live_q, live_d;
  logic                 ovf_q, ovf_d;
  logic                 running_q;
  logic                 tick, carry;
  logic [7:0][3:0]      disp;
  logic                 lap_act;

  always_comb begin
    tick   = (state_q == RUNNING) && (presc_q == PW'(DIV - 1));
    carry  = tick;
    live_d = live_q;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (live_q[i] >= (SIX_MASK[i] ? 4'd5 : 4'd9)) begin
          live_d[i] = 4'd0;
        end else begin
          live_d[i] = live_q[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
    // Carry out of the hours-tens digit means 99:59:59.99 rolled to zero.
    ovf_d   = ovf_q | carry;
    presc_d = presc_q;
    if (state_q == RUNNING) presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    if (sw.start_stop) state_d = (state_q == RUNNING) ? PAUSED : RUNNING;
  end

  always_ff @(posedge clk) begin
    if (reset || sw.clear) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      live_q    <= '0;
      ovf_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      live_q    <= live_d;
      ovf_q     <= ovf_d;
      running_q <= (state_d == RUNNING);
    end
  end

`ifdef LAP_HOLD_EN
  logic [7:0][3:0] disp_q, disp_d;
  logic            lap_q, lap_d;

  always_comb begin
    lap_d = lap_q;
    if (sw.lap && !sw.start_stop) begin
      if (lap_q)                     lap_d = 1'b0;
      else if (state_q == RUNNING)   lap_d = 1'b1;
    end
    // Hold only while the freeze persists; capture and release both load the live value.
    disp_d = (lap_q && lap_d) ? disp_q : live_d;
  end

  always_ff @(posedge clk) begin
    if (reset || sw.clear) begin
      lap_q  <= 1'b0;
      disp_q <= '0;
    end else begin
      lap_q  <= lap_d;
      disp_q <= disp_d;
    end
  end

  assign disp    = disp_q;
  assign lap_act = lap_q;
`else
  logic unused_lap;
  assign unused_lap = sw.lap;
  assign disp       = live_q;
  assign lap_act    = 1'b0;
`endif

  assign sw.bit0       = disp[0];
  assign sw.bit1       = disp[1];
  assign sw.bit2       = disp[2];
  assign sw.bit3       = disp[3];
  assign sw.bit4       = disp[4];
  assign sw.bit5       = disp[5];
  assign sw.bit6       = disp[6];
  assign sw.bit7       = disp[7];
  assign sw.running    = running_q;
  assign sw.ovf        = ovf_q;
  assign sw.lap_active = lap_act;
endmodule
